// File: rtl/jtag_pkg.sv
// Shared JTAG boundary-scan types: the active BSR instruction encoding and a
// helper telling whether the instruction hands the pins over to the chain.
package jtag_pkg;

    typedef enum logic [1:0] {
        FUNCTIONAL = 2'd0,
        SAMPLE     = 2'd1,
        EXTEST     = 2'd2,
        INTEST     = 2'd3
    } bsr_mode_t;

    // EXTEST and INTEST both drive the output pins from the update flops.
    function automatic logic bsr_drives_pins(input bsr_mode_t mode);
        return (mode == EXTEST) || (mode == INTEST);
    endfunction

endpackage

// File: rtl/bsr_cell_sync.sv
// One boundary-scan cell: a shift flop and an update flop sharing the scan
// clock, with synchronous reset taking priority over capture, then shift.
module bsr_cell_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic capture_i,
    input  logic shift_i,
    input  logic update_i,
    input  logic capture_data_i,
    input  logic scan_in_i,
    output logic scan_out_o,
    output logic update_o
);

    logic shift_q;
    logic shift_d;
    logic update_q;
    logic update_d;

    // Capture beats shift when both strobes arrive together; update always
    // latches the shift flop value from before the edge.
    always_comb begin
        shift_d  = shift_q;
        update_d = update_q;
        if (capture_i) begin
            shift_d = capture_data_i;
        end else if (shift_i) begin
            shift_d = scan_in_i;
        end
        if (update_i) begin
            update_d = shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            update_q <= update_d;
        end
    end

    assign scan_out_o = shift_q;
    assign update_o   = update_q;

endmodule

// File: rtl/bsr_chain.sv
// Boundary-scan register: input cells, output cells and (with BSR_OE_CELLS_EN)
// output-enable cells in one serial chain from tdi to tdo, plus pin muxing.
module bsr_chain
    import jtag_pkg::*;
#(
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 2
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               tdi,
    output logic               tdo,
    input  logic               capture_dr,
    input  logic               shift_dr,
    input  logic               update_dr,
    input  bsr_mode_t          bsr_mode,
    input  logic [NUM_IN-1:0]  sys_in,
    output logic [NUM_IN-1:0]  core_in,
    input  logic [NUM_OUT-1:0] core_out,
`ifdef BSR_OE_CELLS_EN
    input  logic [NUM_OUT-1:0] core_oe,
    output logic [NUM_OUT-1:0] sys_oe,
`endif
    output logic [NUM_OUT-1:0] sys_out
);

`ifdef BSR_OE_CELLS_EN
    localparam int CHAIN_LEN = NUM_IN + 2 * NUM_OUT;
`else
    localparam int CHAIN_LEN = NUM_IN + NUM_OUT;
`endif

    logic [CHAIN_LEN-1:0] captureSrc;
    logic [CHAIN_LEN-1:0] scanIn;
    logic [CHAIN_LEN-1:0] shiftBits;
    logic [CHAIN_LEN-1:0] updateBits;

    // Bit k of every vector belongs to cell k, counted from the tdi end.
`ifdef BSR_OE_CELLS_EN
    assign captureSrc = {core_oe, core_out, sys_in};
`else
    assign captureSrc = {core_out, sys_in};
`endif
    assign scanIn = {shiftBits[CHAIN_LEN-2:0], tdi};
    assign tdo    = shiftBits[CHAIN_LEN-1];

    for (genvar k = 0; k < CHAIN_LEN; k++) begin : g_cell
        bsr_cell_sync u_cell (
            .clk_i          (tck),
            .rst_i          (trst),
            .capture_i      (capture_dr),
            .shift_i        (shift_dr),
            .update_i       (update_dr),
            .capture_data_i (captureSrc[k]),
            .scan_in_i      (scanIn[k]),
            .scan_out_o     (shiftBits[k]),
            .update_o       (updateBits[k])
        );
    end

    // Pin/core muxing is purely combinational on bsr_mode.
    always_comb begin
        core_in = sys_in;
        sys_out = core_out;
        if (bsr_mode == INTEST) begin
            core_in = updateBits[NUM_IN-1:0];
        end
        if (bsr_drives_pins(bsr_mode)) begin
            sys_out = updateBits[NUM_IN +: NUM_OUT];
        end
    end

`ifdef BSR_OE_CELLS_EN
    assign sys_oe = bsr_drives_pins(bsr_mode) ? updateBits[NUM_IN+NUM_OUT +: NUM_OUT] : core_oe;
`endif

endmodule
